qa_7seg_serial_loader: RTL and testbench

QA_7SEG_SERIAL_LOADER -- requirements
Module: qa_7seg_serial_loader

---
 rtl/qa_7seg_serial_loader.sv | 118 +++++++++++
 tb/tb_qa_7seg_serial_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/qa_7seg_serial_loader.sv
// ============================================================================
// qa_7seg_serial_loader : MSB-first serial loader for a six-digit 7-seg driver
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module qa_7seg_serial_loader #(
  parameter logic [2:0]  ENABLE_RESET = 3'b000,
  parameter logic [23:0] DATA_RESET   = 24'h000000
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        frameIn,
  input  logic        bitValidIn,
  input  logic        bitIn,
  output logic [2:0]  byteEnableOut,
  output logic [23:0] byteDataOut,
  output logic        frameDoneOut,
  output logic        frameErrOut
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  localparam logic [4:0] FRAME_BITS = 5'd27;

  logic [1:0]  state_q, state_d;
  logic [26:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  en_q, en_d;
  logic [23:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    en_d    = en_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frameIn) begin
          state_d = S_SHIFT;
          sr_d    = 27'd0;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
        end
      end

      S_SHIFT: begin
        if (frameIn) begin
          if (bitValidIn) begin
            // Bits beyond a full frame are dropped but poison the frame.
            if (cnt_q == FRAME_BITS) begin
              ovf_d = 1'b1;
            end else begin
              sr_d  = {sr_q[25:0], bitIn};
              cnt_d = cnt_q + 5'd1;
            end
          end
        end else if ((cnt_q == FRAME_BITS) && !ovf_q) begin
          en_d    = sr_q[26:24];
          data_d  = sr_q[23:0];
          done_d  = 1'b1;
          state_d = S_LATCH;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_LATCH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= S_IDLE;
      sr_q    <= 27'd0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      en_q    <= ENABLE_RESET;
      data_q  <= DATA_RESET;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byteEnableOut = en_q;
  assign byteDataOut   = data_q;
  assign frameDoneOut  = done_q;
  assign frameErrOut   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_qa_7seg_serial_loader.sv
// ============================================================================
// tb_qa_7seg_serial_loader : vector table plus scoreboard for the serial loader
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_qa_7seg_serial_loader;

  localparam logic [2:0]  C_EN_RST   = 3'b110;
  localparam logic [23:0] C_DATA_RST = 24'hC0FFEE;

  logic        clk_in;
  logic        rst_in;
  logic        frame_in;
  logic        bit_valid_in;
  logic        bit_in;
  logic [2:0]  en_out;
  logic [23:0] data_out;
  logic        done_out;
  logic        err_out;

  int n_checks = 0;
  int n_pass   = 0;

  qa_7seg_serial_loader #(
    .ENABLE_RESET (C_EN_RST),
    .DATA_RESET   (C_DATA_RST)
  ) dut (
    .clkIn         (clk_in),
    .rstIn         (rst_in),
    .frameIn       (frame_in),
    .bitValidIn    (bit_valid_in),
    .bitIn         (bit_in),
    .byteEnableOut (en_out),
    .byteDataOut   (data_out),
    .frameDoneOut  (done_out),
    .frameErrOut   (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  en;
    logic [23:0] data;
    int          nbits;
    bit          drop;
    bit          exp_done;
    logic [2:0]  exp_en;
    logic [23:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [2:0]  en;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drives one frame; returns just after the edge that samples frameIn low.
  task automatic send_frame(input logic [26:0] v, input int nbits, input bit drop);
    frame_in     = 1'b1;
    bit_valid_in = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bit_valid_in = 1'b1;
      bit_in       = (i < 27) ? v[26-i] : i[0];
      tick();
    end
    frame_in     = 1'b0;
    bit_valid_in = drop;
    bit_in       = (drop && nbits <= 26) ? v[26-nbits] : 1'b0;
    tick();
    bit_valid_in = 1'b0;
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (done_out || err_out) begin
      chk("pulse_exclusive", {31'd0, done_out & err_out}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: done=%b err=%b with no frame outstanding at %0t",
                 done_out, err_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_done", {31'd0, done_out}, {31'd0, e.done});
        chk("sb_err",  {31'd0, err_out},  {31'd0, e.err});
        chk("sb_en",   {29'd0, en_out},   {29'd0, e.en});
        chk("sb_data", {8'd0, data_out},  {8'd0, e.data});
      end
    end
  end

  initial begin
    vecs[0] = '{3'b101, 24'h12ABCD, 27, 1'b0, 1'b1, 3'b101, 24'h12ABCD};
    vecs[1] = '{3'b010, 24'h555555, 26, 1'b0, 1'b0, 3'b101, 24'h12ABCD};
    vecs[2] = '{3'b011, 24'h0F0F0F, 30, 1'b0, 1'b0, 3'b101, 24'h12ABCD};
    vecs[3] = '{3'b110, 24'h765432, 26, 1'b1, 1'b0, 3'b101, 24'h12ABCD};
    vecs[4] = '{3'b000, 24'h000001, 27, 1'b0, 1'b1, 3'b000, 24'h000001};
    vecs[5] = '{3'b000, 24'h000002, 27, 1'b0, 1'b1, 3'b000, 24'h000002};
    vecs[6] = '{3'b111, 24'h999999, 0,  1'b0, 1'b0, 3'b000, 24'h000002};
    vecs[7] = '{3'b010, 24'hABCDEF, 27, 1'b0, 1'b1, 3'b010, 24'hABCDEF};

    rst_in       = 1'b1;
    frame_in     = 1'b0;
    bit_valid_in = 1'b0;
    bit_in       = 1'b0;
    repeat (3) tick();
    chk("rst_en",   {29'd0, en_out},   {29'd0, C_EN_RST});
    chk("rst_data", {8'd0, data_out},  {8'd0, C_DATA_RST});
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_err",  {31'd0, err_out},  32'd0);

    // Strobes with no frame open must be ignored.
    rst_in       = 1'b0;
    bit_valid_in = 1'b1;
    bit_in       = 1'b1;
    repeat (3) tick();
    bit_valid_in = 1'b0;
    chk("idle_en",   {29'd0, en_out},  {29'd0, C_EN_RST});
    chk("idle_data", {8'd0, data_out}, {8'd0, C_DATA_RST});

    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.done = vecs[k].exp_done;
      e.err  = !vecs[k].exp_done;
      e.en   = vecs[k].exp_en;
      e.data = vecs[k].exp_data;
      sb.push_back(e);
      send_frame({vecs[k].en, vecs[k].data}, vecs[k].nbits, vecs[k].drop);
      chk($sformatf("v%0d_done", k), {31'd0, done_out}, {31'd0, vecs[k].exp_done});
      chk($sformatf("v%0d_err", k),  {31'd0, err_out},  {31'd0, !vecs[k].exp_done});
      chk($sformatf("v%0d_en", k),   {29'd0, en_out},   {29'd0, vecs[k].exp_en});
      chk($sformatf("v%0d_data", k), {8'd0, data_out},  {8'd0, vecs[k].exp_data});
      tick();
      chk($sformatf("v%0d_done_low", k), {31'd0, done_out}, 32'd0);
      chk($sformatf("v%0d_err_low", k),  {31'd0, err_out},  32'd0);
      chk($sformatf("v%0d_hold", k),     {8'd0, data_out},  {8'd0, vecs[k].exp_data});
    end

    // Reset 13 bits into a frame, frameIn still high across the reset.
    frame_in = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      bit_valid_in = 1'b1;
      bit_in       = i[0];
      tick();
    end
    rst_in = 1'b1;
    tick();
    bit_valid_in = 1'b0;
    chk("midrst_en",   {29'd0, en_out},   {29'd0, C_EN_RST});
    chk("midrst_data", {8'd0, data_out},  {8'd0, C_DATA_RST});
    chk("midrst_done", {31'd0, done_out}, 32'd0);
    chk("midrst_err",  {31'd0, err_out},  32'd0);
    rst_in = 1'b0;
    begin
      exp_t e;
      e = '{done: 1'b1, err: 1'b0, en: 3'b111, data: 24'hFFFFFF};
      sb.push_back(e);
    end
    send_frame({3'b111, 24'hFFFFFF}, 27, 1'b0);
    chk("postrst_done", {31'd0, done_out}, 32'd1);
    chk("postrst_en",   {29'd0, en_out},   {29'd0, 3'b111});
    chk("postrst_data", {8'd0, data_out},  {8'd0, 24'hFFFFFF});

    repeat (4) tick();
    chk("sb_drain", sb.size(), 32'd0);
    chk("final_data", {8'd0, data_out}, {8'd0, 24'hFFFFFF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
